program_bus_decoder: RTL and testbench
======================================

# program_bus_decoder

Decodes the 6502 address bus for the program ROM space, holds the ROM bank latch, and generates the active-low chip selects and bank lines consumed by the program memory block. Registers the selects one cycle so they align with the synchronous ROM read data, and returns a valid strobe and a held read-data byte to the CPU data mux. Optionally contains the watchdog that resets the CPU when software stops kicking it.

## Interface
- WDOG_FRAMES, 8: vblank rising edges without a kick before the watchdog fires (1..255).
- WDOG_PULSE, 16: watchdog reset pulse length in clocks (1..255).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_en  in  1  CPU bus-cycle strobe; address, data and rw are sampled only when high.
- cpu_addr  in  16  CPU address.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_dout  in  8  CPU write data (unused by the decode itself; reserved for bank latch extensions).
- vblank  in  1  video vertical blank level.
- rom_data  in  8  byte returned by program memory, valid one clock after the address is presented.
- rom_addr  out  13  = cpu_addr[12:0], combinational.
- ROM0n, ROM1n, ROM2n  out  1 each  registered active-low chip selects.
- BANK0n, BANK1n  out  1 each  registered complementary bank lines.
- rom_valid  out  1  one-clock pulse; rom_rdata valid.
- rom_rdata  out  8  last ROM byte captured; holds between reads.
- wdog_reset  out  1  watchdog CPU reset request.

## Operation
- Memory map, decoded only on cpu_en=1:
  - 0xA000–0xBFFF read: ROM0 (banked).
  - 0xC000–0xDFFF read: ROM1 (banked).
  - 0xE000–0xFFFF read: ROM2 (fixed).
  - write 0x9F80: bank 0 → BANK0n=0, BANK1n=1.
  - write 0x9F81: bank 1 → BANK0n=1, BANK1n=0.
  - write 0x9600–0x96FF: watchdog kick.
- Writes to ROM ranges are ignored: no select, no valid.
- Select register: on a ROM read with cpu_en=1, exactly one of ROM0n/ROM1n/ROM2n goes low for the next clock, then all return high. At most one select is low at any time.
- Bank lines are always complementary. A bank write takes effect on the clock after the write cycle. A bank write and a ROM read never coincide: they share the same bus cycle and are mutually exclusive by address.
- Read pipeline, two states:
  - IDLE: on ROM read strobe → ISSUE.
  - ISSUE: selects low, rom_data sampled at end of this clock into rom_rdata; rom_valid=1 on the following clock; returns to IDLE.
  - A new ROM read strobe arriving in ISSUE is accepted, back-to-back: ISSUE repeats with new selects, one valid per read.
- Bank line used for a read is the value registered at issue. A bank write on the immediately preceding cycle is honoured.

## Timing
- Reset values: ROM0n=ROM1n=ROM2n=1, BANK0n=1, BANK1n=0, rom_valid=0, rom_rdata=0x00, wdog_reset=0, state IDLE, watchdog counter 0.
- Latency: cpu_en read at edge N → selects low during N+1 → rom_valid high during N+2 with data.
- Throughput: one read per clock.
- Reset asserted mid-read aborts the pipeline. No valid is produced for the aborted read.
- vblank rising edge uses a registered edge detect, so the first edge counts one clock after it appears on the pin.

## Configuration
- PROGRAM_BUS_WDOG_EN defined:
  - The watchdog counts vblank rising edges and clears on a kick.
  - When the count reaches WDOG_FRAMES, wdog_reset goes high for WDOG_PULSE clocks, then the counter clears.
  - A kick and a vblank edge in the same clock → kick wins, count = 0.
  - Kicks during the pulse do not shorten it.
- Not defined: wdog_reset tied 0, no counter logic, kick writes ignored.

## Test plan
- Reset, then read 0xE123 → rom_addr=0x0123; ROM2n low exactly one clock; rom_valid on the 2nd clock; rom_rdata = ROM byte.
- Write 0x9F80, read 0xA010 → BANK0n=0 and ROM0n low during the issue clock. Write 0x9F81, read 0xC010 → BANK0n=1 and ROM1n low.
- Back-to-back reads 0xA000, 0xC000, 0xE000 on consecutive clocks → three consecutive single-select clocks, three consecutive valids, data in order.
- Write 0xA000 → no select, no valid. cpu_en=0 with address 0xE000 → no activity.
- Assert reset during the issue clock → selects high next clock, no valid, BANK0n=1.
- WDOG_EN, WDOG_FRAMES=8, WDOG_PULSE=16: 8 vblank edges with no kick → wdog_reset high exactly 16 clocks. Kick at 0x9600 after 7 edges → no reset.

Source files
------------

// File: rtl/program_bus_decoder.sv
// Program ROM address decoder for the 6502 bus: registered chip selects, bank latch, read pipeline.
// Optional vblank watchdog enabled with `define PROGRAM_BUS_WDOG_EN.
module program_bus_decoder #(
  parameter int WDOG_FRAMES = 8,
  parameter int WDOG_PULSE  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic        vblank,
  input  logic [7:0]  rom_data,
  output logic [12:0] rom_addr,
  output logic        ROM0n,
  output logic        ROM1n,
  output logic        ROM2n,
  output logic        BANK0n,
  output logic        BANK1n,
  output logic        rom_valid,
  output logic [7:0]  rom_rdata,
  output logic        wdog_reset
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t     state, state_next;
  logic [2:0] sel_n_next;
  logic       rd_strobe;
  logic       bank_wr0, bank_wr1;

  assign rom_addr = cpu_addr[12:0];
  assign bank_wr0 = cpu_en && !cpu_rw && (cpu_addr == 16'h9F80);
  assign bank_wr1 = cpu_en && !cpu_rw && (cpu_addr == 16'h9F81);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    sel_n_next = 3'b111;
    state_next = IDLE;
    if (cpu_en && cpu_rw) begin
      case (cpu_addr[15:13])
        3'b101:  sel_n_next = 3'b110;
        3'b110:  sel_n_next = 3'b101;
        3'b111:  sel_n_next = 3'b011;
        default: sel_n_next = 3'b111;
      endcase
    end
    rd_strobe = (sel_n_next != 3'b111);
    case (state)
      IDLE:    if (rd_strobe) state_next = ISSUE;
      ISSUE:   state_next = rd_strobe ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      {ROM2n, ROM1n, ROM0n} <= 3'b111;
      BANK0n               <= 1'b1;
      BANK1n               <= 1'b0;
      rom_valid            <= 1'b0;
      rom_rdata            <= 8'h00;
    end else begin
      state                <= state_next;
      {ROM2n, ROM1n, ROM0n} <= sel_n_next;
      if (bank_wr0)      {BANK0n, BANK1n} <= 2'b01;
      else if (bank_wr1) {BANK0n, BANK1n} <= 2'b10;
      rom_valid <= (state == ISSUE);
      // The synchronous ROM returns data for the issued address during the ISSUE clock.
      if (state == ISSUE) rom_rdata <= rom_data;
    end
  end

`ifdef PROGRAM_BUS_WDOG_EN
  logic       kick;
  logic       vblank_q, vblank_rise;
  logic [7:0] frame_cnt;
  logic [7:0] pulse_cnt;
  logic       unused;

  assign kick       = cpu_en && !cpu_rw && (cpu_addr[15:8] == 8'h96);
  assign wdog_reset = (pulse_cnt != 8'd0);
  assign unused     = ^cpu_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q    <= 1'b0;
      vblank_rise <= 1'b0;
      frame_cnt   <= 8'd0;
      pulse_cnt   <= 8'd0;
    end else begin
      vblank_q    <= vblank;
      vblank_rise <= vblank && !vblank_q;
      // An active pulse runs to completion; kicks and frames are ignored until it ends.
      if (pulse_cnt != 8'd0) begin
        pulse_cnt <= pulse_cnt - 8'd1;
        if (pulse_cnt == 8'd1) frame_cnt <= 8'd0;
      end else if (kick) begin
        frame_cnt <= 8'd0;
      end else if (vblank_rise) begin
        if (frame_cnt == 8'(WDOG_FRAMES - 1)) begin
          frame_cnt <= 8'(WDOG_FRAMES);
          pulse_cnt <= 8'(WDOG_PULSE);
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end
`else
  logic unused;

  assign wdog_reset = 1'b0;
  assign unused     = ^{cpu_dout, vblank, 8'(WDOG_FRAMES), 8'(WDOG_PULSE)};
`endif

endmodule

// File: tb/tb_program_bus_decoder.sv
// Directed bench for program_bus_decoder: decode, bank latch, read pipeline, reset abort, watchdog.
module tb_program_bus_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic        vblank;
  logic [7:0]  rom_data;
  logic [12:0] rom_addr;
  logic        ROM0n, ROM1n, ROM2n, BANK0n, BANK1n;
  logic        rom_valid;
  logic [7:0]  rom_rdata;
  logic        wdog_reset;

  int vectors     = 0;
  int miscompares = 0;
  int wd_highs    = 0;

  program_bus_decoder #(.WDOG_FRAMES(8), .WDOG_PULSE(16)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .vblank(vblank), .rom_data(rom_data), .rom_addr(rom_addr),
    .ROM0n(ROM0n), .ROM1n(ROM1n), .ROM2n(ROM2n), .BANK0n(BANK0n), .BANK1n(BANK1n),
    .rom_valid(rom_valid), .rom_rdata(rom_rdata), .wdog_reset(wdog_reset)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: byte for address A is A[15:8] ^ A[7:0], one clock later.
  always @(posedge clk) rom_data <= cpu_addr[15:8] ^ cpu_addr[7:0];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (wdog_reset) wd_highs++;
  endtask

  task automatic bus(input logic en, input logic rw, input logic [15:0] addr);
    cpu_en   = en;
    cpu_rw   = rw;
    cpu_addr = addr;
  endtask

  task automatic vb_edge();
    vblank = 1'b1; step(); step();
    vblank = 1'b0; step(); step();
  endtask

  initial begin
    reset = 1'b1; cpu_dout = 8'h5A; vblank = 1'b0;
    bus(1'b0, 1'b1, 16'h0000);
    step(); step();
    check("reset_sel",   {13'd0, ROM2n, ROM1n, ROM0n}, 16'h7);
    check("reset_bank",  {14'd0, BANK0n, BANK1n}, 16'h2);
    check("reset_valid", {15'd0, rom_valid}, 16'h0);
    check("reset_rdata", {8'd0, rom_rdata}, 16'h00);
    check("reset_wdog",  {15'd0, wdog_reset}, 16'h0);
    reset = 1'b0; step();

    // Single read from ROM2.
    bus(1'b1, 1'b1, 16'hE123); #1;
    check("e123_addr", {3'd0, rom_addr}, 16'h0123);
    step(); bus(1'b0, 1'b1, 16'h0000);
    check("e123_sel",   {13'd0, ROM2n, ROM1n, ROM0n}, 16'h3);
    check("e123_noval", {15'd0, rom_valid}, 16'h0);
    step();
    check("e123_selhi", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h7);
    check("e123_valid", {15'd0, rom_valid}, 16'h1);
    check("e123_data",  {8'd0, rom_rdata}, 16'h00C2);
    step();
    check("e123_vdrop", {15'd0, rom_valid}, 16'h0);
    check("e123_hold",  {8'd0, rom_rdata}, 16'h00C2);

    // Bank 0 then read ROM0.
    bus(1'b1, 1'b0, 16'h9F80); step();
    bus(1'b1, 1'b1, 16'hA010);
    check("bank0_lines", {14'd0, BANK0n, BANK1n}, 16'h1);
    step(); bus(1'b0, 1'b1, 16'h0000);
    check("a010_sel",  {13'd0, ROM2n, ROM1n, ROM0n}, 16'h6);
    check("a010_bank", {15'd0, BANK0n}, 16'h0);
    step();
    check("a010_valid", {15'd0, rom_valid}, 16'h1);
    check("a010_data",  {8'd0, rom_rdata}, 16'h00B0);

    // Bank 1 then read ROM1.
    bus(1'b1, 1'b0, 16'h9F81); step();
    bus(1'b1, 1'b1, 16'hC010); step(); bus(1'b0, 1'b1, 16'h0000);
    check("c010_sel",  {13'd0, ROM2n, ROM1n, ROM0n}, 16'h5);
    check("c010_bank", {14'd0, BANK0n, BANK1n}, 16'h2);
    step();
    check("c010_data", {8'd0, rom_rdata}, 16'h00D0);

    // Back-to-back reads.
    bus(1'b1, 1'b1, 16'hA000); step();
    check("b2b0_sel", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h6);
    bus(1'b1, 1'b1, 16'hC000); step();
    check("b2b1_sel", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h5);
    check("b2b0_val", {15'd0, rom_valid}, 16'h1);
    check("b2b0_dat", {8'd0, rom_rdata}, 16'h00A0);
    bus(1'b1, 1'b1, 16'hE000); step();
    check("b2b2_sel", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h3);
    check("b2b1_val", {15'd0, rom_valid}, 16'h1);
    check("b2b1_dat", {8'd0, rom_rdata}, 16'h00C0);
    bus(1'b0, 1'b1, 16'h0000); step();
    check("b2b_selhi", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h7);
    check("b2b2_val",  {15'd0, rom_valid}, 16'h1);
    check("b2b2_dat",  {8'd0, rom_rdata}, 16'h00E0);
    step();
    check("b2b_end", {15'd0, rom_valid}, 16'h0);

    // Write to ROM space and disabled strobe produce nothing.
    bus(1'b1, 1'b0, 16'hA000); step(); bus(1'b0, 1'b1, 16'hE000);
    check("wr_rom_sel", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h7);
    step();
    check("wr_rom_val", {15'd0, rom_valid}, 16'h0);
    check("noen_sel",   {13'd0, ROM2n, ROM1n, ROM0n}, 16'h7);
    step();
    check("noen_val",  {15'd0, rom_valid}, 16'h0);
    check("noen_hold", {8'd0, rom_rdata}, 16'h00E0);

    // Reset during the issue clock aborts the read.
    bus(1'b1, 1'b0, 16'h9F80); step();
    bus(1'b1, 1'b1, 16'hA010); step(); bus(1'b0, 1'b1, 16'h0000);
    check("abort_issue", {13'd0, ROM2n, ROM1n, ROM0n}, 16'h6);
    reset = 1'b1; step();
    check("abort_sel",   {13'd0, ROM2n, ROM1n, ROM0n}, 16'h7);
    check("abort_val",   {15'd0, rom_valid}, 16'h0);
    check("abort_bank",  {14'd0, BANK0n, BANK1n}, 16'h2);
    check("abort_rdata", {8'd0, rom_rdata}, 16'h00);
    reset = 1'b0; step();
    check("abort_noval", {15'd0, rom_valid}, 16'h0);

    // Watchdog.
    wd_highs = 0;
`ifdef PROGRAM_BUS_WDOG_EN
    for (int i = 0; i < 7; i++) vb_edge();
    check("wd_7edges", wd_highs[15:0], 16'd0);
    vb_edge();
    for (int i = 0; i < 30; i++) step();
    check("wd_pulse_len", wd_highs[15:0], 16'd16);
    check("wd_pulse_end", {15'd0, wdog_reset}, 16'h0);
    wd_highs = 0;
    for (int i = 0; i < 7; i++) vb_edge();
    bus(1'b1, 1'b0, 16'h9600); step(); bus(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 7; i++) vb_edge();
    step(); step();
    check("wd_kicked", wd_highs[15:0], 16'd0);
    vb_edge();
    for (int i = 0; i < 30; i++) step();
    check("wd_after_kick", wd_highs[15:0], 16'd16);
`else
    for (int i = 0; i < 10; i++) vb_edge();
    bus(1'b1, 1'b0, 16'h9600); step(); bus(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 20; i++) step();
    check("wd_disabled", wd_highs[15:0], 16'd0);
    check("wd_tied",     {15'd0, wdog_reset}, 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
